// File: rtl/ex_muldiv_unit.sv
// ============================================================================
//  Module   : ex_muldiv_unit
//  Brief    : Iterative MIPS-style multiply/divide unit with HI/LO registers.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module ex_muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int ITERS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_in,
  input  logic            flush_in,
  input  logic [2:0]      op_in,
  input  logic [XLEN-1:0] rs_val_in,
  input  logic [XLEN-1:0] rt_val_in,
  output logic            stall_out,
  output logic            busy_out,
  output logic            done_out,
  output logic [XLEN-1:0] hi_out,
  output logic [XLEN-1:0] lo_out,
  output logic [XLEN-1:0] mf_result_out
);

  localparam int         c_CNT_W   = (ITERS > 1) ? $clog2(ITERS) : 1;
  localparam logic [2:0] c_OP_MULT = 3'd0;
  localparam logic [2:0] c_OP_DIV  = 3'd2;
  localparam logic [2:0] c_OP_MFHI = 3'd4;
  localparam logic [2:0] c_OP_MFLO = 3'd5;
  localparam logic [2:0] c_OP_MTHI = 3'd6;
  localparam logic [2:0] c_OP_MTLO = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t               r_state;
  logic [c_CNT_W-1:0]   r_count;
  logic [XLEN-1:0]      r_hi;
  logic [XLEN-1:0]      r_lo;
  logic                 r_done;
  logic                 r_is_div;
  logic                 r_neg_q;
  logic                 r_neg_r;
  logic                 r_div0;
  logic [XLEN-1:0]      r_rs_raw;
  logic [XLEN-1:0]      r_opnd_a;
  logic [XLEN-1:0]      r_acc_hi;
  logic [XLEN-1:0]      r_acc_lo;

  logic                 w_accept;
  logic                 w_signed;
  logic                 w_rs_neg;
  logic                 w_rt_neg;
  logic [XLEN-1:0]      w_rs_mag;
  logic [XLEN-1:0]      w_rt_mag;
  logic                 w_op_div;
  logic [XLEN:0]        w_mul_sum;
  logic [XLEN:0]        w_div_shift;
  logic [XLEN:0]        w_div_diff;
  logic                 w_div_ge;
  logic [2*XLEN-1:0]    w_prod;
  logic [2*XLEN-1:0]    w_prod_fix;
  logic [XLEN-1:0]      w_quot;
  logic [XLEN-1:0]      w_rem;

  assign busy_out  = (r_state != S_IDLE);
  assign stall_out = start_in & ~flush_in & busy_out;
  assign w_accept  = start_in & ~flush_in & ~stall_out;
  assign done_out  = r_done;
  assign hi_out    = r_hi;
  assign lo_out    = r_lo;

  assign w_op_div = op_in[1];
  assign w_signed = (op_in == c_OP_MULT) | (op_in == c_OP_DIV);
  assign w_rs_neg = w_signed & rs_val_in[XLEN-1];
  assign w_rt_neg = w_signed & rt_val_in[XLEN-1];
  assign w_rs_mag = w_rs_neg ? -rs_val_in : rs_val_in;
  assign w_rt_mag = w_rt_neg ? -rt_val_in : rt_val_in;

  // Multiply: r_acc_lo holds the multiplier and fills with product low bits.
  assign w_mul_sum = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_opnd_a} : {(XLEN+1){1'b0}});

  // Divide: r_acc_hi is the partial remainder, r_acc_lo shifts dividend out / quotient in.
  assign w_div_shift = {r_acc_hi, r_acc_lo[XLEN-1]};
  assign w_div_diff  = w_div_shift - {1'b0, r_opnd_a};
  assign w_div_ge    = ~w_div_diff[XLEN];

  assign w_prod     = {r_acc_hi, r_acc_lo};
  assign w_prod_fix = r_neg_q ? -w_prod : w_prod;
  assign w_quot     = r_neg_q ? -r_acc_lo : r_acc_lo;
  assign w_rem      = r_neg_r ? -r_acc_hi : r_acc_hi;

  always_comb begin
    mf_result_out = '0;
    if (op_in == c_OP_MFHI) begin
      mf_result_out = r_hi;
    end else if (op_in == c_OP_MFLO) begin
      mf_result_out = r_lo;
    end
  end

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_count  <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_done   <= 1'b0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_div0   <= 1'b0;
      r_rs_raw <= '0;
      r_opnd_a <= '0;
      r_acc_hi <= '0;
      r_acc_lo <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (!op_in[2]) begin
              r_is_div <= w_op_div;
              r_neg_q  <= w_rs_neg ^ w_rt_neg;
              r_neg_r  <= w_rs_neg;
              r_div0   <= w_op_div & (rt_val_in == '0);
              r_rs_raw <= rs_val_in;
              r_opnd_a <= w_op_div ? w_rt_mag : w_rs_mag;
              r_acc_hi <= '0;
              r_acc_lo <= w_op_div ? w_rs_mag : w_rt_mag;
              r_count  <= c_CNT_W'(ITERS - 1);
              r_state  <= S_RUN;
            end else if (op_in == c_OP_MTHI) begin
              r_hi <= rs_val_in;
            end else if (op_in == c_OP_MTLO) begin
              r_lo <= rs_val_in;
            end
          end
        end
        S_RUN: begin
          if (r_is_div) begin
            r_acc_hi <= w_div_ge ? w_div_diff[XLEN-1:0] : w_div_shift[XLEN-1:0];
            r_acc_lo <= {r_acc_lo[XLEN-2:0], w_div_ge};
          end else begin
            {r_acc_hi, r_acc_lo} <= {w_mul_sum, r_acc_lo[XLEN-1:1]};
          end
          if (r_count == '0) begin
            r_state <= S_FIX;
          end else begin
            r_count <= r_count - 1'b1;
          end
        end
        S_FIX: begin
          if (!r_is_div) begin
            r_hi <= w_prod_fix[2*XLEN-1:XLEN];
            r_lo <= w_prod_fix[XLEN-1:0];
          end else if (r_div0) begin
            // Divide by zero reports the raw dividend, bypassing sign fix-up.
            r_hi <= r_rs_raw;
            r_lo <= '1;
          end else begin
            r_hi <= w_rem;
            r_lo <= w_quot;
          end
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
